// File: rtl/keypad_event_queue.sv
// Debounces a one-hot keypad position and queues one key code per accepted press
// in a 4-entry first-word-fall-through FIFO.
module keypad_event_queue #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] posicion,
    input  logic        rd_en,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [2:0]  fifo_count,
    output logic        fifo_full,
    output logic        overflow,
    output logic        key_held
);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [15:0] sample, sample_next;
    logic        push;
    logic        one_hot;

    logic [3:0]  mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic        pop, accept;

    function automatic logic [3:0] encode(input logic [15:0] v);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) code = 4'(i);
        end
        return code;
    endfunction

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign one_hot = (posicion != 16'd0) && ((posicion & (posicion - 16'd1)) == 16'd0);

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        sample_next = sample;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    sample_next = posicion;
                    cnt_next    = 8'd0;
                    state_next  = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (posicion == sample) begin
                    if (cnt == CNT_LAST) begin
                        push       = 1'b1;
                        state_next = PRESSED;
                    end else begin
                        cnt_next = cnt + 8'd1;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            PRESSED: begin
                if (posicion != sample) begin
                    cnt_next   = 8'd0;
                    state_next = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (posicion == 16'd0) begin
                    if (cnt == CNT_LAST) state_next = IDLE;
                    else                 cnt_next   = cnt + 8'd1;
                end else if (posicion == sample) begin
                    state_next = PRESSED;
                end else begin
                    cnt_next = 8'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            sample <= 16'd0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            sample <= sample_next;
        end
    end

    // A full queue still takes a push when the head leaves on the same edge.
    assign pop    = rd_en && key_valid;
    assign accept = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            overflow   <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 2'd1;
            if (pop)    rd_ptr <= rd_ptr + 2'd1;
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
            overflow <= push && fifo_full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= encode(sample);
    end

    assign key_valid = (fifo_count != 3'd0);
    assign fifo_full = (fifo_count == 3'd4);
    assign key_code  = key_valid ? mem[rd_ptr] : 4'd0;
    assign key_held  = (state == PRESSED) || (state == DEB_RELEASE);

endmodule

// File: tb/tb_keypad_event_queue.sv
// Randomized and directed bench for keypad_event_queue against a queue-based reference model.
module tb_keypad_event_queue;

    localparam int D = 4;
    localparam int M_IDLE = 0, M_DEB_PRESS = 1, M_PRESSED = 2, M_DEB_RELEASE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] posicion = 16'd0;
    logic        rd_en = 1'b0;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        overflow;
    logic        key_held;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    int          m_state = M_IDLE;
    int          m_cnt = 0;
    logic [15:0] m_sample = 16'd0;
    int          m_q[$];
    bit          m_ovf = 1'b0;

    keypad_event_queue #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .posicion(posicion), .rd_en(rd_en),
        .key_code(key_code), .key_valid(key_valid), .fifo_count(fifo_count),
        .fifo_full(fifo_full), .overflow(overflow), .key_held(key_held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [15:0] p, input logic r, input logic rs);
        bit push = 1'b0;
        bit full, pop;
        if (rs) begin
            m_state = M_IDLE; m_cnt = 0; m_sample = 16'd0; m_ovf = 1'b0;
            m_q.delete();
            return;
        end
        case (m_state)
            M_IDLE: if ($countones(p) == 1) begin
                m_sample = p; m_cnt = 0; m_state = M_DEB_PRESS;
            end
            M_DEB_PRESS: if (p == m_sample) begin
                if (m_cnt == D - 1) begin push = 1'b1; m_state = M_PRESSED; end
                else m_cnt++;
            end else m_state = M_IDLE;
            M_PRESSED: if (p != m_sample) begin m_cnt = 0; m_state = M_DEB_RELEASE; end
            default: begin
                if (p == 16'd0) begin
                    if (m_cnt == D - 1) m_state = M_IDLE;
                    else m_cnt++;
                end else if (p == m_sample) m_state = M_PRESSED;
                else m_cnt = 0;
            end
        endcase
        full  = (m_q.size() == 4);
        pop   = r && (m_q.size() > 0);
        m_ovf = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (!full || pop) m_q.push_back($clog2(m_sample));
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic [15:0] p, input logic r = 1'b0, input logic rs = 1'b0);
        posicion = p; rd_en = r; rst = rs;
        @(posedge clk);
        model_edge(p, r, rs);
        #1;
    endtask

    task automatic press(input int code, input int hold = 6, input int rel = 6);
        for (int i = 0; i < hold; i++) step(16'd1 << code);
        for (int i = 0; i < rel; i++) step(16'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(key_valid), 0);
        chk({tag, "_count"}, int'(fifo_count), 0);
        chk({tag, "_full"}, int'(fifo_full), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_held"}, int'(key_held), 0);
        chk({tag, "_code"}, int'(key_code), 0);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_key_valid", int'(key_valid), int'(m_q.size() > 0));
            chk("m_fifo_count", int'(fifo_count), m_q.size());
            chk("m_fifo_full", int'(fifo_full), int'(m_q.size() == 4));
            chk("m_overflow", int'(overflow), int'(m_ovf));
            chk("m_key_held", int'(key_held), int'(m_state == M_PRESSED || m_state == M_DEB_RELEASE));
            chk("m_key_code", int'(key_code), (m_q.size() > 0) ? m_q[0] : 0);
        end
    end

    initial begin
        int ovf_seen;
        int exp_codes[4];
        logic [15:0] v;
        int len;

        step(16'd0, 1'b0, 1'b1);
        cmp_en = 1'b1;
        chk_all_zero("reset");

        // Single press held for a long time: one push, no auto-repeat.
        for (int i = 0; i < 104; i++) begin
            step(16'h0020);
            if (i == 3) chk("press_early_valid", int'(key_valid), 0);
            if (i == 4) begin
                chk("press_valid", int'(key_valid), 1);
                chk("press_code", int'(key_code), 5);
            end
        end
        chk("hold_count", int'(fifo_count), 1);
        chk("hold_held", int'(key_held), 1);
        step(16'd0, 1'b0, 1'b1);

        // Short glitch: no push.
        step(16'h0001); step(16'h0001);
        for (int i = 0; i < 10; i++) step(16'd0);
        chk("glitch_count", int'(fifo_count), 0);

        // Multi-bit value never starts a press.
        for (int i = 0; i < 50; i++) step(16'h0003);
        chk("multi_held", int'(key_held), 0);
        chk("multi_count", int'(fifo_count), 0);

        // Five presses into a 4-deep queue.
        press(0); press(1); press(2); press(3);
        ovf_seen = 0;
        for (int i = 0; i < 6; i++) begin step(16'h8000); ovf_seen += int'(overflow); end
        for (int i = 0; i < 6; i++) begin step(16'd0); ovf_seen += int'(overflow); end
        chk("ovf_pulses", ovf_seen, 1);
        chk("ovf_full", int'(fifo_full), 1);
        for (int k = 0; k < 4; k++) begin
            chk("ovf_pop_code", int'(key_code), k);
            step(16'd0, 1'b1);
        end
        chk("ovf_empty", int'(key_valid), 0);
        step(16'd0, 1'b1);
        chk("empty_pop_count", int'(fifo_count), 0);

        // Push and pop on the same edge while full, then a release bounce.
        step(16'd0, 1'b0, 1'b1);
        press(4); press(5); press(6); press(7);
        for (int i = 0; i < 4; i++) step(16'h0200);
        step(16'h0200, 1'b1);
        chk("simul_count", int'(fifo_count), 4);
        chk("simul_ovf", int'(overflow), 0);
        step(16'd0); step(16'h0200);
        chk("bounce_held", int'(key_held), 1);
        for (int i = 0; i < 6; i++) step(16'd0);
        chk("bounce_count", int'(fifo_count), 4);
        exp_codes = '{5, 6, 7, 9};
        for (int k = 0; k < 4; k++) begin
            chk("simul_pop_code", int'(key_code), exp_codes[k]);
            step(16'd0, 1'b1);
        end

        // Reset mid-debounce, and with three entries queued while a key is held.
        step(16'h0010); step(16'h0010);
        step(16'h0010, 1'b0, 1'b1);
        chk_all_zero("rst_deb");
        press(1); press(2); press(3, 8, 0);
        chk("pre_rst_count", int'(fifo_count), 3);
        step(16'h0008, 1'b0, 1'b1);
        chk_all_zero("rst_q3");
        for (int i = 0; i < 5; i++) step(16'h0008);
        chk("repress_valid", int'(key_valid), 1);
        chk("repress_code", int'(key_code), 3);

        // Randomized segments.
        for (int seg = 0; seg < 900; seg++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: v = 16'd0;
                4, 5, 6, 7, 8: v = 16'd1 << $urandom_range(0, 15);
                default: v = 16'($urandom);
            endcase
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++)
                step(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 499) == 0));
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
